// File: rtl/cache_arbiter.sv
// Shares one burst memory port between the instruction and data caches:
// one 256-bit line request at a time, serialized into a 4-beat, 64-bit burst.
module cache_arbiter #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64,
  parameter int BEATS  = LINE_W / BEAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [31:0]       i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [31:0]       d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_addr,
  output logic [BEAT_W-1:0] mem_wdata,
  input  logic [BEAT_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  localparam int BEAT_CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BEATS - 1);
  localparam logic [31:0] LINE_MASK = ~(32'(LINE_W / 8) - 32'd1);

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;
  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;

  state_t                  state_reg, state_next;
  owner_t                  owner_reg, owner_next;
  owner_t                  last_reg, last_next;
  logic [BEAT_CNT_W-1:0]   beat_reg, beat_next;
  logic [31:0]             addr_reg, addr_next;
  logic [LINE_W-1:0]       line_reg, line_next;

  logic                    d_req;
  logic                    grant_d;
  logic                    grant_i;
  logic [BEAT_W-1:0]       line_beats [BEATS];

  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_slice
      assign line_beats[gi] = line_reg[gi*BEAT_W +: BEAT_W];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      owner_reg <= OWN_I;
      last_reg  <= OWN_I;
      beat_reg  <= '0;
      addr_reg  <= '0;
      line_reg  <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      last_reg  <= last_next;
      beat_reg  <= beat_next;
      addr_reg  <= addr_next;
      line_reg  <= line_next;
    end
  end

  // Contested grants go to whichever cache was not served last.
  assign d_req   = d_read | d_write;
  assign grant_d = d_req && (!i_read || (last_reg == OWN_I));
  assign grant_i = i_read && !grant_d;

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    last_next  = last_reg;
    beat_next  = beat_reg;
    addr_next  = addr_reg;
    line_next  = line_reg;
    case (state_reg)
      IDLE: begin
        if (grant_d) begin
          owner_next = OWN_D;
          last_next  = OWN_D;
          addr_next  = d_addr & LINE_MASK;
          beat_next  = '0;
          if (d_write) begin
            line_next  = d_wdata;
            state_next = WR_BURST;
          end else begin
            state_next = RD_BURST;
          end
        end else if (grant_i) begin
          owner_next = OWN_I;
          last_next  = OWN_I;
          addr_next  = i_addr & LINE_MASK;
          beat_next  = '0;
          state_next = RD_BURST;
        end
      end
      RD_BURST: begin
        if (mem_resp) begin
          line_next[BEAT_W*beat_reg +: BEAT_W] = mem_rdata;
          beat_next = beat_reg + BEAT_CNT_W'(1);
          if (beat_reg == LAST_BEAT) state_next = DONE;
        end
      end
      WR_BURST: begin
        if (mem_resp) begin
          beat_next = beat_reg + BEAT_CNT_W'(1);
          if (beat_reg == LAST_BEAT) state_next = DONE;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign mem_read  = (state_reg == RD_BURST);
  assign mem_write = (state_reg == WR_BURST);
  assign mem_addr  = addr_reg;
  assign mem_wdata = mem_write ? line_beats[beat_reg] : '0;
  assign i_resp    = (state_reg == DONE) && (owner_reg == OWN_I);
  assign d_resp    = (state_reg == DONE) && (owner_reg == OWN_D);
  assign i_rdata   = line_reg;
  assign d_rdata   = line_reg;

endmodule
